raw8_frame_packer: RTL
======================

Name: raw8_frame_packer

Overview:
- Sits between the MIPI CSI-2 RAW8 byte/pixel decoder and the dual-clock frame RAM (32-bit words, 17-bit word address, 76800 words deep).
- Packs four consecutive 8-bit pixels into one 32-bit word, little-endian: the first pixel of each group goes to [7:0].
- Generates the frame-RAM word address and write strobe, with line/frame bookkeeping, short/long-line handling and error flagging.
- The HDMI side then reads pixel n at word n>>2, byte lane n[1:0].

Parameters:
- H_ACTIVE, 640: active pixels per line; must be a multiple of 4.
- V_ACTIVE, 480: active lines per frame.
- ADDR_W, 17: word address width; must hold H_ACTIVE*V_ACTIVE/4-1.

Ports:
- clk  in  1  single clock, the CSI byte clock domain; all logic rises on posedge.
- reset  in  1  asynchronous active-low reset; 0 = reset.
- fs_i  in  1  frame-start pulse, one cycle.
- ls_i  in  1  line-start pulse, one cycle.
- le_i  in  1  line-end pulse, one cycle.
- pix_valid_i  in  1  pix_i carries a valid pixel this cycle.
- pix_i  in  8  RAW8 pixel.
- data_o  out  32  packed word to RAM port A.
- adress_o  out  ADDR_W  RAM word address.
- we_o  out  1  write strobe, one cycle per word.
- frame_done_o  out  1  one-cycle pulse when line V_ACTIVE-1 ends.
- frame_cnt_o  out  8  completed-frame counter; wraps 255->0.
- err_o  out  1  sticky error flag; cleared only by reset or the next fs_i.

Behaviour:
- Reset (async assert, sync release): data_o=0, adress_o=0, we_o=0, frame_done_o=0, frame_cnt_o=0, err_o=0, state=WAIT_FS, byte index=0, line base=0, line count=0.
- State WAIT_FS: ignore everything except fs_i. fs_i -> WAIT_LS; clear line base, line count and err_o.
- State WAIT_LS: ls_i -> LINE; clear byte index and word-in-line count. pix_valid_i here is dropped and sets err_o.
- State LINE: each pix_valid_i writes pix_i into byte lane idx[1:0], then idx increments.
  - On the 4th byte: next cycle we_o=1, data_o=packed word, adress_o=line_base+word_in_line; word_in_line increments.
  - Latency: 1 cycle from the 4th pixel to we_o.
- Long line: pixels beyond H_ACTIVE in the current line are dropped and set err_o. No write occurs past line_base+H_ACTIVE/4-1.
- le_i in LINE:
  - If pix_valid_i is in the same cycle, that pixel is accepted first and is the last pixel of the line.
  - If idx!=0 (short line, partial word): flush one word next cycle with missing upper lanes zero. Any short line (total pixels < H_ACTIVE) sets err_o.
  - Then line_base += H_ACTIVE/4 (adder, no multiplier) and line count increments.
  - If line count reaches V_ACTIVE: frame_done_o pulses with the final write or flush cycle (or the cycle after le_i if there is nothing to write), frame_cnt_o increments, state -> WAIT_FS. Otherwise state -> WAIT_LS.
- fs_i in WAIT_LS or LINE (aborted frame): any partial word is discarded unwritten, err_o=1 (latched after the clear for this case), state -> WAIT_LS with line_base=0. fs_i has priority over ls_i, le_i and pix_valid_i in the same cycle; a pixel in that cycle is dropped.
- ls_i while in LINE (missing le_i): treated as le_i (flush and advance), then the new line starts; err_o=1.
- Addresses never exceed H_ACTIVE*V_ACTIVE/4-1. Line count saturates; no wrap within a frame.
- we_o is never asserted for more than one cycle per word. Back-to-back words at one pixel per cycle give we_o every 4th cycle.
- Reset mid-line: all state is cleared immediately; no write for the partial word.

Optional Feature:
- Macro RAW8_FRAME_PACKER_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt_o [7:0]: a saturating count (max 255) of individual error events (long line, short line, missing le, aborted frame, pixel outside LINE).
  - Cleared by reset only; not cleared by fs_i.
  - err_o behaviour is unchanged.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Full frame, H_ACTIVE=8, V_ACTIVE=2, pixels 0x00..0x0F in order:
  - we_o pulses 4 times: addr 0..3, data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
  - frame_done_o pulses once; frame_cnt_o=1; err_o=0.
- Short line, H_ACTIVE=8, line 0 gets 6 pixels 0xA0..0xA5:
  - writes addr0=0xA3A2A1A0, then flush addr1=0x0000A5A4.
  - Line 1 starts at addr 2; err_o=1.
- Long line, 10 pixels on line 0 (H_ACTIVE=8): only addr 0,1 written; pixels 9 and 10 dropped; err_o=1; line 1 base is addr 2.
- fs_i after 3 pixels of line 1: no write of the partial word; the next frame's first word lands at addr 0; err_o=1.
- le_i in the same cycle as the 8th pixel: the pixel is packed and the word written to addr 1 one cycle later; no extra flush; err_o=0.
- Reset asserted mid-line after 2 pixels, then a clean frame: all outputs are 0 during reset; the clean frame writes from addr 0 with correct data; frame_cnt_o=1. With RAW8_FRAME_PACKER_ERR_CNT_EN, err_cnt_o=0.

Source files
------------

// File: rtl/raw8_frame_packer.sv
// raw8_frame_packer: packs RAW8 pixels four-per-word (first pixel in [7:0])
// and generates frame-RAM word address / write strobe with line and frame
// bookkeeping, short/long/missing-le/aborted-frame error flagging.
// Optional feature macro: RAW8_FRAME_PACKER_ERR_CNT_EN adds err_cnt_o, a
// saturating count of individual error events (cleared by reset only).
module raw8_frame_packer #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fs_i,
  input  logic              ls_i,
  input  logic              le_i,
  input  logic              pix_valid_i,
  input  logic [7:0]        pix_i,
  output logic [31:0]       data_o,
  output logic [ADDR_W-1:0] adress_o,
  output logic              we_o,
  output logic              frame_done_o,
  output logic [7:0]        frame_cnt_o,
  output logic              err_o
`ifdef RAW8_FRAME_PACKER_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt_o
`endif
);

  localparam int unsigned WPL = H_ACTIVE / 4;
  localparam int unsigned WW  = $clog2(WPL + 1);
  localparam int unsigned LW  = $clog2(V_ACTIVE + 1);
  localparam logic [WW-1:0]     WPL_L = WW'(WPL);
  localparam logic [LW-1:0]     VL    = LW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] WPL_A = ADDR_W'(WPL);

  typedef enum logic [1:0] {
    WAIT_FS = 2'd0,
    WAIT_LS = 2'd1,
    LINE    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [1:0]          r_idx;
  logic [WW-1:0]       r_word;
  logic [LW-1:0]       r_lcnt;
  logic [ADDR_W-1:0]   r_base;
  logic [31:0]         r_buf;
  logic [31:0]         r_data;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic                r_done;
  logic [7:0]          r_fcnt;
  logic                r_err;

  logic                w_start;
  logic                w_abort;
  logic                w_ls_open;
  logic                w_in_line;
  logic                w_acc;
  logic                w_long;
  logic                w_stray;
  logic                w_eol;
  logic                w_miss_le;
  logic                w_full;
  logic [1:0]          w_idx_nxt;
  logic [WW-1:0]       w_word_nxt;
  logic                w_flush;
  logic                w_short;
  logic [LW-1:0]       w_lcnt_inc;
  logic                w_last;
  logic                w_write;
  logic                w_err_evt;
  logic [31:0]         w_buf_nxt;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= WAIT_FS;
    else        r_state <= w_state_nxt;
  end

  // Next-state: fs_i dominates; end of line either closes the frame or
  // opens the next line (ls_i without le_i) or waits for the next ls_i
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      WAIT_FS: if (fs_i) w_state_nxt = WAIT_LS;
      WAIT_LS: begin
        if (fs_i)      w_state_nxt = WAIT_LS;
        else if (ls_i) w_state_nxt = LINE;
      end
      LINE: begin
        if (fs_i)          w_state_nxt = WAIT_LS;
        else if (w_eol) begin
          if (w_last)      w_state_nxt = WAIT_FS;
          else if (ls_i)   w_state_nxt = LINE;
          else             w_state_nxt = WAIT_LS;
        end
      end
      default: w_state_nxt = WAIT_FS;
    endcase
  end

  // Per-cycle decode of pixel acceptance, writes, line end and error events
  always_comb begin
    w_start    = fs_i && (r_state == WAIT_FS);
    w_abort    = fs_i && (r_state != WAIT_FS);
    w_ls_open  = !fs_i && (r_state == WAIT_LS) && ls_i;
    w_stray    = !fs_i && (r_state == WAIT_LS) && pix_valid_i;
    w_in_line  = !fs_i && (r_state == LINE);
    w_acc      = w_in_line && pix_valid_i && (r_word != WPL_L);
    w_long     = w_in_line && pix_valid_i && (r_word == WPL_L);
    w_eol      = w_in_line && (le_i || ls_i);
    w_miss_le  = w_in_line && ls_i && !le_i;
    w_full     = w_acc && (r_idx == 2'd3);
    w_idx_nxt  = r_idx + 2'(w_acc);
    w_word_nxt = r_word + WW'(w_full);
    // a pixel arriving with le_i is counted before the partial-word test
    w_flush    = w_eol && (w_idx_nxt != 2'd0);
    w_short    = w_eol && (w_word_nxt != WPL_L);
    w_lcnt_inc = (r_lcnt == VL) ? r_lcnt : r_lcnt + LW'(1);
    w_last     = w_eol && (w_lcnt_inc == VL);
    w_write    = w_full || w_flush;
    w_err_evt  = w_long || w_stray || w_short || w_miss_le;
    w_buf_nxt  = r_buf;
    if (w_acc) w_buf_nxt[8*r_idx +: 8] = pix_i;
  end

  // Datapath: packing buffer, line/frame counters, registered RAM outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx  <= '0;
      r_word <= '0;
      r_lcnt <= '0;
      r_base <= '0;
      r_buf  <= '0;
      r_data <= '0;
      r_addr <= '0;
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_fcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_we   <= w_write;
      r_done <= w_last;
      if (w_write) begin
        r_data <= w_buf_nxt;
        r_addr <= r_base + ADDR_W'(r_word);
      end
      if (w_last) r_fcnt <= r_fcnt + 8'd1;

      if (w_start || w_abort) begin
        r_base <= '0;
        r_lcnt <= '0;
        r_idx  <= '0;
        r_word <= '0;
        r_buf  <= '0;
      end else if (w_eol) begin
        // base is frozen on the last line so no address can exceed the frame
        if (!w_last) r_base <= r_base + WPL_A;
        r_lcnt <= w_lcnt_inc;
        r_idx  <= '0;
        r_word <= '0;
        r_buf  <= '0;
      end else if (w_ls_open) begin
        r_idx  <= '0;
        r_word <= '0;
        r_buf  <= '0;
      end else if (w_acc) begin
        r_idx  <= w_idx_nxt;
        r_word <= w_word_nxt;
        r_buf  <= w_full ? '0 : w_buf_nxt;
      end

      // fs_i in WAIT_FS clears; an aborting fs_i clears and re-latches
      if (w_start)                   r_err <= 1'b0;
      else if (w_abort || w_err_evt) r_err <= 1'b1;
    end
  end

  assign data_o       = r_data;
  assign adress_o     = r_addr;
  assign we_o         = r_we;
  assign frame_done_o = r_done;
  assign frame_cnt_o  = r_fcnt;
  assign err_o        = r_err;

`ifdef RAW8_FRAME_PACKER_ERR_CNT_EN
  logic [7:0] r_ecnt;
  logic [2:0] w_ev_n;
  logic [8:0] w_ecnt_sum;

  // Number of distinct error events this cycle, added with saturation
  always_comb begin
    w_ev_n     = 3'(w_long) + 3'(w_stray) + 3'(w_short) + 3'(w_miss_le) + 3'(w_abort);
    w_ecnt_sum = {1'b0, r_ecnt} + {6'b0, w_ev_n};
  end

  // Saturating error-event counter, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             r_ecnt <= '0;
    else if (w_ecnt_sum[8]) r_ecnt <= '1;
    else                    r_ecnt <= w_ecnt_sum[7:0];
  end

  assign err_cnt_o = r_ecnt;
`endif

endmodule
